// File: rtl/pipelined_compressor_tree_3_to_2_pkg.sv
// Elaboration-time helpers for sizing the 3:2 compressor tree: level count,
// term count after a given number of levels, and register stage count.
package compressor_tree_pkg;

    function automatic int num_levels(input int n);
        int m;
        int c;
        m = n;
        c = 0;
        while (m > 2) begin
            m = (m / 3) * 2 + m % 3;
            c++;
        end
        return c;
    endfunction

    function automatic int level_width(input int n, input int lvl);
        int m;
        m = n;
        for (int i = 0; i < lvl; i++) begin
            if (m > 2) m = (m / 3) * 2 + m % 3;
        end
        return m;
    endfunction

    function automatic int num_stages(input int n, input int levels_per_stage);
        int l;
        l = num_levels(n);
        return (l == 0) ? 1 : (l + levels_per_stage - 1) / levels_per_stage;
    endfunction

endpackage

// File: rtl/pipelined_compressor_tree_3_to_2_if.sv
// Operand/result handshake bundle for the compressor tree.
// COMPRESSOR_TREE_FINAL_CPA_EN adds the SUM result vector.
interface pipelined_compressor_tree_3_to_2_if #(
    parameter int NUM_ELEMENTS = 9,
    parameter int BIT_LEN      = 16,
    parameter int TAG_LEN      = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [BIT_LEN-1:0] terms [NUM_ELEMENTS];
    logic [TAG_LEN-1:0] in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [BIT_LEN-1:0] C;
    logic [BIT_LEN-1:0] S;
    logic [TAG_LEN-1:0] out_tag;
`ifdef COMPRESSOR_TREE_FINAL_CPA_EN
    logic [BIT_LEN-1:0] SUM;

    modport slave  (input  in_valid, terms, in_tag, out_ready,
                    output in_ready, out_valid, C, S, out_tag, SUM);
    modport master (output in_valid, terms, in_tag, out_ready,
                    input  in_ready, out_valid, C, S, out_tag, SUM);
`else
    modport slave  (input  in_valid, terms, in_tag, out_ready,
                    output in_ready, out_valid, C, S, out_tag);
    modport master (output in_valid, terms, in_tag, out_ready,
                    input  in_ready, out_valid, C, S, out_tag);
`endif
endinterface

// File: rtl/pipelined_compressor_tree_3_to_2_stage.sv
// One pipeline stage: LEVELS levels of 3:2 compression followed by a
// data/tag/valid register that loads when empty or when downstream loads.
module compressor_pipe_stage
    import compressor_tree_pkg::*;
#(
    parameter int IN_ELEMENTS = 3,
    parameter int LEVELS      = 1,
    parameter int BIT_LEN     = 16,
    parameter int TAG_LEN     = 4,
    localparam int OUT_ELEMENTS = level_width(IN_ELEMENTS, LEVELS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic [BIT_LEN-1:0] i_terms [IN_ELEMENTS],
    input  logic [TAG_LEN-1:0] i_tag,
    input  logic               i_next_load,
    output logic               o_load,
    output logic               o_valid,
    output logic [BIT_LEN-1:0] o_terms [OUT_ELEMENTS],
    output logic [TAG_LEN-1:0] o_tag
);

    function automatic logic [BIT_LEN-1:0] carry_vec(
        input logic [BIT_LEN-1:0] a, b, c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    logic [BIT_LEN-1:0] w_work [IN_ELEMENTS];
    logic [BIT_LEN-1:0] w_next [IN_ELEMENTS];
    logic [BIT_LEN-1:0] w_red  [OUT_ELEMENTS];
    logic               r_valid;
    logic [BIT_LEN-1:0] r_terms [OUT_ELEMENTS];
    logic [TAG_LEN-1:0] r_tag;

    // Each level: full adders over index-ordered triples, leftovers appended.
    always_comb begin : reduce
        int n;
        w_work = i_terms;
        w_next = i_terms;
        n = IN_ELEMENTS;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            w_next = w_work;
            for (int g = 0; g < IN_ELEMENTS / 3; g++) begin
                if (3 * g + 2 < n) begin
                    w_next[2*g]   = w_work[3*g] ^ w_work[3*g+1] ^ w_work[3*g+2];
                    w_next[2*g+1] = carry_vec(w_work[3*g], w_work[3*g+1], w_work[3*g+2]);
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < n % 3) w_next[2*(n/3)+r] = w_work[3*(n/3)+r];
            end
            w_work = w_next;
            n = (n / 3) * 2 + n % 3;
        end
        for (int i = 0; i < OUT_ELEMENTS; i++) w_red[i] = w_work[i];
    end

    assign o_load = !r_valid || i_next_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_terms <= '{default: '0};
        end else if (o_load) begin
            r_valid <= i_valid;
            r_tag   <= i_tag;
            r_terms <= w_red;
        end
    end

    assign o_valid = r_valid;
    assign o_terms = r_terms;
    assign o_tag   = r_tag;

endmodule

// File: rtl/pipelined_compressor_tree_3_to_2.sv
// Pipelined 3:2 compressor tree reducing NUM_ELEMENTS terms to a C/S pair.
// COMPRESSOR_TREE_FINAL_CPA_EN appends a registered carry-propagate stage (SUM).
module pipelined_compressor_tree_3_to_2
    import compressor_tree_pkg::*;
#(
    parameter int NUM_ELEMENTS     = 9,
    parameter int BIT_LEN          = 16,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_LEN          = 4
) (
    input logic clk,
    input logic rst,
    pipelined_compressor_tree_3_to_2_if.slave bus
);

    localparam int L       = num_levels(NUM_ELEMENTS);
    localparam int P       = num_stages(NUM_ELEMENTS, LEVELS_PER_STAGE);
    localparam int FINAL_W = level_width(NUM_ELEMENTS, L);

    logic [P:0]              w_load;
    logic [P:0]              w_valid;
    logic [P:0][TAG_LEN-1:0] w_tag;
    logic [BIT_LEN-1:0]      w_fin_s;
    logic [BIT_LEN-1:0]      w_fin_c;

    assign w_valid[0]  = bus.in_valid;
    assign w_tag[0]    = bus.in_tag;
    assign bus.in_ready = w_load[0];

    for (genvar k = 0; k < P; k++) begin : g_stage
        localparam int FIRST = k * LEVELS_PER_STAGE;
        localparam int NLEV  = (L - FIRST < LEVELS_PER_STAGE) ? L - FIRST : LEVELS_PER_STAGE;
        localparam int IN_W  = level_width(NUM_ELEMENTS, FIRST);
        localparam int OUT_W = level_width(NUM_ELEMENTS, FIRST + NLEV);

        logic [BIT_LEN-1:0] w_in  [IN_W];
        logic [BIT_LEN-1:0] w_out [OUT_W];

        if (k == 0) begin : g_src
            assign w_in = bus.terms;
        end else begin : g_src
            assign w_in = g_stage[k-1].w_out;
        end

        compressor_pipe_stage #(
            .IN_ELEMENTS (IN_W),
            .LEVELS      (NLEV),
            .BIT_LEN     (BIT_LEN),
            .TAG_LEN     (TAG_LEN)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_valid     (w_valid[k]),
            .i_terms     (w_in),
            .i_tag       (w_tag[k]),
            .i_next_load (w_load[k+1]),
            .o_load      (w_load[k]),
            .o_valid     (w_valid[k+1]),
            .o_terms     (w_out),
            .o_tag       (w_tag[k+1])
        );
    end

    assign w_fin_s = g_stage[P-1].w_out[0];
    if (FINAL_W > 1) begin : g_fin_c
        assign w_fin_c = g_stage[P-1].w_out[1];
    end else begin : g_fin_c
        assign w_fin_c = '0;
    end

`ifdef COMPRESSOR_TREE_FINAL_CPA_EN
    logic               r_cpa_valid;
    logic [BIT_LEN-1:0] r_cpa_c;
    logic [BIT_LEN-1:0] r_cpa_s;
    logic [BIT_LEN-1:0] r_cpa_sum;
    logic [TAG_LEN-1:0] r_cpa_tag;

    assign w_load[P] = !r_cpa_valid || bus.out_ready;

    // Carry-propagate output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpa_valid <= 1'b0;
            r_cpa_c     <= '0;
            r_cpa_s     <= '0;
            r_cpa_sum   <= '0;
            r_cpa_tag   <= '0;
        end else if (w_load[P]) begin
            r_cpa_valid <= w_valid[P];
            r_cpa_c     <= w_fin_c;
            r_cpa_s     <= w_fin_s;
            r_cpa_sum   <= w_fin_c + w_fin_s;
            r_cpa_tag   <= w_tag[P];
        end
    end

    assign bus.out_valid = r_cpa_valid;
    assign bus.C         = r_cpa_c;
    assign bus.S         = r_cpa_s;
    assign bus.SUM       = r_cpa_sum;
    assign bus.out_tag   = r_cpa_tag;
`else
    assign w_load[P]     = bus.out_ready;
    assign bus.out_valid = w_valid[P];
    assign bus.C         = w_fin_c;
    assign bus.S         = w_fin_s;
    assign bus.out_tag   = w_tag[P];
`endif

endmodule

// File: doc/pipelined_compressor_tree_3_to_2.md
Name: pipelined_compressor_tree_3_to_2

Overview:
Parameterised, pipelined tree of 3:2 carry-save compressors. It reduces NUM_ELEMENTS operands of BIT_LEN bits to a carry/sum pair, with C + S equal to the sum of all terms mod 2^BIT_LEN. Register stages are inserted every LEVELS_PER_STAGE compressor levels. A valid/ready handshake with per-stage backpressure lets the block sit between multiplier partial-product generators and downstream adders or accumulators in the modular-arithmetic datapath.

Parameters:
- NUM_ELEMENTS, 9, number of input terms (>=1).
- BIT_LEN, 16, width of every term and of C/S.
- LEVELS_PER_STAGE, 2, compressor levels per register stage (>=1).
- TAG_LEN, 4, width of the sideband tag carried alongside each operand set (>=1).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operand set
- terms  input  [BIT_LEN-1:0] x NUM_ELEMENTS (unpacked)  operands
- in_tag  input  TAG_LEN  sideband, passed through unchanged
- out_valid  output  1  C/S/out_tag valid
- out_ready  input  1  downstream accepts
- C  output  BIT_LEN  carry vector, already left-aligned (bit 0 = 0 when produced by a compressor)
- S  output  BIT_LEN  sum vector
- out_tag  output  TAG_LEN  tag matching C/S

Behaviour:
- Level count L: start with n = NUM_ELEMENTS; while n > 2, set n = (n/3)*2 + n%3 and count one level. Examples: N=9 gives L=4; N=3 gives L=1; N<=2 gives L=0.
- Each level groups terms in threes, in index order, into full-adder compressors. Leftover terms (n%3) pass through in order after the compressor outputs.
- Each compressor's carry output is shifted left by 1; the MSB carry is dropped (mod 2^BIT_LEN).
- Final mapping: two terms map to S=term0, C=term1. One term maps to S=term0, C=0.
- Stage count P = max(1, ceil(L/LEVELS_PER_STAGE)). Each stage is LEVELS_PER_STAGE combinational levels followed by a register holding data, tag and a valid bit.
- The last stage may hold fewer levels. When L=0, a single pass-through register stage exists.
- Latency is exactly P cycles from in_valid&&in_ready to out_valid, assuming no stall. Example: N=9, LEVELS_PER_STAGE=2 gives P=2.
- Handshake: stage k loads when v[k]==0 or stage k+1 loads. For the last stage, "stage k+1 loads" means out_ready.
  - in_ready = !v[0] || (stage 1 load condition). It is combinational from out_ready through the chain.
  - Bubbles collapse, so sustained throughput is 1 operand set per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, C/S/out_tag hold stable. Upstream stages fill, then in_ready drops; the block holds at most P sets.
- Data registers load only on their stage load condition. Invalid stages may hold stale data, but out_valid=0 masks it.
- Reset: all valid bits clear asynchronously, so out_valid=0 and in_ready=1 after reset.
  - C, S and out_tag reset to 0.
  - Sets in flight when rst asserts are discarded; nothing partial emerges after release.
- Simultaneous accept and emit on a full pipe: allowed in the same cycle with no bubble.

Optional Feature:
- Macro: COMPRESSOR_TREE_FINAL_CPA_EN.
- When defined:
  - Adds one output stage with a carry-propagate adder, registering SUM = C + S mod 2^BIT_LEN.
  - Adds output port SUM [BIT_LEN-1:0]; C and S remain as the registered inputs of that stage.
  - Latency becomes P+1; the handshake rules extend over the extra stage.
  - SUM resets to 0.
- When undefined: no SUM port, latency P.

Decomposition:
- Package compressor_tree_pkg holds:
  - function num_levels(n) implementing the level recurrence
  - function level_width(n, lvl), the term count after lvl levels
  - function num_stages(n, levels_per_stage)
- One sub-module, compressor_pipe_stage: parameters IN_ELEMENTS, LEVELS, BIT_LEN, TAG_LEN.
  - Comb reduction plus register, valid bit and load logic.
  - The top instantiates P of these via a generate loop, with stage widths from the package functions.

Test Plan:
- N=9, BIT_LEN=16, LEVELS_PER_STAGE=2, terms = 1..9, tag=5, out_ready=1 -> out_valid after exactly 2 cycles; (C+S) mod 65536 = 45; out_tag = 5.
- Same config, nine terms all 16'hFFFF -> (C+S) mod 65536 = 16'hFFF7 (wrap-around; dropped MSB carries do not corrupt the result).
- Back-to-back 20 random sets with out_ready=1 -> 20 outputs on 20 consecutive cycles, in order, tags 0..19 matching.
- out_ready held 0 for 5 cycles while feeding -> in_ready drops after 2 accepted sets; C/S stable. Release -> both sets drain in order with no loss or duplication.
- N=2 (terms 7, 3) -> S=7, C=3 after 1 cycle. N=1 (term 7) -> S=7, C=0.
- rst asserted with 2 sets in flight -> out_valid=0, in_ready=1 and C/S/out_tag/SUM = 0 immediately, with no clock needed. After release no stale output appears.
- With COMPRESSOR_TREE_FINAL_CPA_EN defined, the terms 1..9 case -> SUM=45 after 3 cycles.
